// File: rtl/apply_literal_pkg.sv
// Shared formula types (package common) and the apply_literal state encoding.
// The optional UNIT_DETECT_EN build adds no types; it reuses lit.
package common;
  localparam int num_clauses = 16;
  localparam int clause_len  = 4;
  localparam int var_w       = 5;
  localparam int len_w       = $clog2(clause_len + 1);
  localparam int idx_w       = $clog2(clause_len);
  localparam int iter_w      = $clog2(num_clauses);

  typedef struct packed {
    logic [var_w-1:0] num;
    logic             val;
  } lit;

  typedef struct packed {
    logic [len_w-1:0]      len;
    lit [clause_len-1:0]   lits;
  } clause;

  typedef clause [num_clauses-1:0] formula;

  localparam lit     zero_lit     = '0;
  localparam formula zero_formula = '0;
endpackage

package apply_literal_pkg;
  import common::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // True when every clause slot is deleted (len == 0).
  function automatic logic formula_empty(input formula f);
    logic empty;
    empty = 1'b1;
    for (int i = 0; i < num_clauses; i++) begin
      if (f[i].len != '0) empty = 1'b0;
    end
    return empty;
  endfunction
endpackage

// File: rtl/apply_literal_if.sv
// Request/result bundle for apply_literal; unit_found/unit_lit exist only
// when UNIT_DETECT_EN is defined.
interface apply_literal_if;
  import common::*;

  // start is a single-shot request sampled only while idle; there is no
  // ready. busy covers the scan, done pulses once and the result outputs
  // stay valid until the next done.
  logic   start;
  formula formula_in;
  lit     lit_in;
  logic   busy;
  logic   done;
  formula formula_out;
  logic   conflict;
  logic   satisfied;
`ifdef UNIT_DETECT_EN
  logic   unit_found;
  lit     unit_lit;

  modport master (output start, formula_in, lit_in,
                  input  busy, done, formula_out, conflict, satisfied,
                         unit_found, unit_lit);
  modport slave  (input  start, formula_in, lit_in,
                  output busy, done, formula_out, conflict, satisfied,
                         unit_found, unit_lit);
`else
  modport master (output start, formula_in, lit_in,
                  input  busy, done, formula_out, conflict, satisfied);
  modport slave  (input  start, formula_in, lit_in,
                  output busy, done, formula_out, conflict, satisfied);
`endif
endinterface

// File: rtl/apply_literal_strike.sv
// clause_strike: applies one literal to one clause. Deletes the clause when
// satisfied, otherwise removes opposite literals and compacts survivors left.
module apply_literal_strike
  import common::*;
(
  input  clause clause_i,
  input  lit    lit_i,
  output clause clause_o,
  output logic  sat_o,
  output logic  emptied_o
);
  logic [len_w-1:0] cnt;

  always_comb begin
    clause_o  = '0;
    sat_o     = 1'b0;
    emptied_o = 1'b0;
    cnt       = '0;
    for (int k = 0; k < clause_len; k++) begin
      if (len_w'(k) < clause_i.len && clause_i.lits[k] == lit_i) sat_o = 1'b1;
    end
    if (clause_i.len == '0) begin
      clause_o = clause_i;
    end else if (!sat_o) begin
      // Any occurrence of lit_i.num here must be the opposite polarity.
      for (int k = 0; k < clause_len; k++) begin
        if (len_w'(k) < clause_i.len && clause_i.lits[k].num != lit_i.num) begin
          clause_o.lits[cnt[idx_w-1:0]] = clause_i.lits[k];
          cnt = cnt + len_w'(1);
        end
      end
      clause_o.len = cnt;
      emptied_o    = (cnt == '0);
    end
  end
endmodule

// File: rtl/apply_literal.sv
// apply_literal: scans one clause per cycle applying a decided literal, then
// reports the simplified formula with conflict/satisfied (and, with
// UNIT_DETECT_EN, the first unit clause).
module apply_literal
  import common::*, apply_literal_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  apply_literal_if.slave bus,
  output state_e dbg_state_o
);
  localparam logic [iter_w-1:0] LAST_ITER = iter_w'(num_clauses - 1);

  state_e              state_q, state_d;
  logic [iter_w-1:0]   iter_q, iter_d;
  formula              work_q, work_d;
  lit                  lit_q, lit_d;
  logic                acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  formula              fout_q, fout_d;
  logic                conflict_q, conflict_d;
  logic                sat_q, sat_d;
`ifdef UNIT_DETECT_EN
  logic                unit_found_q, unit_found_d;
  lit                  unit_lit_q, unit_lit_d;
`endif

  clause strike_clause;
  logic  strike_sat;
  logic  strike_emptied;

  apply_literal_strike u_strike (
    .clause_i  (work_q[iter_q]),
    .lit_i     (lit_q),
    .clause_o  (strike_clause),
    .sat_o     (strike_sat),
    .emptied_o (strike_emptied)
  );

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    work_d     = work_q;
    lit_d      = lit_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fout_d     = fout_q;
    conflict_d = conflict_q;
    sat_d      = sat_q;
`ifdef UNIT_DETECT_EN
    unit_found_d = unit_found_q;
    unit_lit_d   = unit_lit_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.formula_in;
          lit_d   = bus.lit_in;
          acc_d   = 1'b0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        work_d[iter_q] = strike_sat ? '0 : strike_clause;
        if (strike_emptied) acc_d = 1'b1;
        if (iter_q == LAST_ITER) begin
          // Results are registered as the last clause lands, so done and
          // the outputs become visible together in the FINISH cycle.
          iter_d     = '0;
          state_d    = FINISH;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fout_d     = work_d;
          conflict_d = acc_d;
          sat_d      = !acc_d && formula_empty(work_d);
`ifdef UNIT_DETECT_EN
          unit_found_d = 1'b0;
          unit_lit_d   = zero_lit;
          for (int i = num_clauses - 1; i >= 0; i--) begin
            if (!acc_d && work_d[i].len == len_w'(1)) begin
              unit_found_d = 1'b1;
              unit_lit_d   = work_d[i].lits[0];
            end
          end
`endif
        end else begin
          iter_d = iter_q + iter_w'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      work_q     <= zero_formula;
      lit_q      <= zero_lit;
      acc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fout_q     <= zero_formula;
      conflict_q <= 1'b0;
      sat_q      <= 1'b0;
`ifdef UNIT_DETECT_EN
      unit_found_q <= 1'b0;
      unit_lit_q   <= zero_lit;
`endif
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      work_q     <= work_d;
      lit_q      <= lit_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fout_q     <= fout_d;
      conflict_q <= conflict_d;
      sat_q      <= sat_d;
`ifdef UNIT_DETECT_EN
      unit_found_q <= unit_found_d;
      unit_lit_q   <= unit_lit_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.formula_out = fout_q;
  assign bus.conflict    = conflict_q;
  assign bus.satisfied   = sat_q;
`ifdef UNIT_DETECT_EN
  assign bus.unit_found  = unit_found_q;
  assign bus.unit_lit    = unit_lit_q;
`endif
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_apply_literal.sv
// Directed and random checks of apply_literal against a behavioural model;
// covers UNIT_DETECT_EN outputs when that macro is defined.
module tb_apply_literal;
  import common::*, apply_literal_pkg::*;

  localparam int W = $bits(formula);

  logic   clock;
  logic   reset;
  state_e dbg_state;
  int     vectors;
  int     miscompares;

  logic [W-1:0]          exp_q[$];
  logic [1:0]            exp_flag_q[$];
  logic [$bits(lit):0]   exp_unit_q[$];

  apply_literal_if bus ();

  apply_literal dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic lit mk_lit(input int num, input int val);
    lit l;
    l.num = var_w'(num);
    l.val = 1'(val);
    return l;
  endfunction

  function automatic clause mk_clause(input int len, input lit a, input lit b, input lit c, input lit d);
    clause cl;
    cl.len     = len_w'(len);
    cl.lits[0] = a;
    cl.lits[1] = b;
    cl.lits[2] = c;
    cl.lits[3] = d;
    return cl;
  endfunction

  function automatic formula rand_formula(input int max_var);
    formula f;
    for (int i = 0; i < num_clauses; i++) begin
      f[i].len = len_w'($urandom_range(0, clause_len));
      for (int k = 0; k < clause_len; k++) begin
        f[i].lits[k].num = var_w'($urandom_range(0, max_var));
        f[i].lits[k].val = 1'($urandom_range(0, 1));
      end
    end
    return f;
  endfunction

  // Reference model: builds each surviving clause by appending kept literals.
  task automatic model(input formula f, input lit l, output formula fo,
                       output logic confl, output logic sat,
                       output logic ufound, output lit ulit);
    fo     = f;
    confl  = 1'b0;
    ufound = 1'b0;
    ulit   = zero_lit;
    for (int i = 0; i < num_clauses; i++) begin
      clause c;
      clause n;
      bit    hit;
      int    m;
      c = f[i];
      if (c.len == 0) continue;
      hit = 0;
      for (int k = 0; k < int'(c.len); k++) if (c.lits[k] == l) hit = 1;
      n = '0;
      if (!hit) begin
        m = 0;
        for (int k = 0; k < int'(c.len); k++) begin
          if (c.lits[k].num != l.num) begin
            n.lits[m] = c.lits[k];
            m++;
          end
        end
        n.len = len_w'(m);
        if (m == 0) confl = 1'b1;
      end
      fo[i] = n;
    end
    sat = !confl;
    for (int i = 0; i < num_clauses; i++) if (fo[i].len != 0) sat = 1'b0;
    for (int i = 0; i < num_clauses; i++) begin
      if (!confl && !ufound && fo[i].len == 1) begin
        ufound = 1'b1;
        ulit   = fo[i].lits[0];
      end
    end
  endtask

  // One request; optional extra start pulse at cycle second_at and optional
  // reset at cycle reset_at (cycle 1 is the first cycle after acceptance).
  task automatic run_op(input string tag, input formula f, input lit l,
                        input int second_at, input int reset_at);
    formula ef;
    logic   ec, es, uf;
    lit     ul;
    int     n;
    int     dones;
    model(f, l, ef, ec, es, uf, ul);
    if (reset_at < 0) begin
      exp_q.push_back(ef);
      exp_flag_q.push_back({ec, es});
      exp_unit_q.push_back({uf, ul});
    end
    @(negedge clock);
    bus.formula_in = f;
    bus.lit_in     = l;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n     = 1;
    dones = 0;
    while (n <= 40) begin
      if (n == second_at)     bus.start = 1'b1;
      if (n == second_at + 1) bus.start = 1'b0;
      if (n == reset_at) begin
        #1 reset = 1'b0;
        #1;
        check({tag, "_rst_busy"}, bus.busy, 1'b0);
        check({tag, "_rst_done"}, bus.done, 1'b0);
        check({tag, "_rst_conflict"}, bus.conflict, 1'b0);
        check({tag, "_rst_sat"}, bus.satisfied, 1'b0);
        check({tag, "_rst_fout"}, bus.formula_out, zero_formula);
        check({tag, "_rst_state"}, dbg_state, IDLE);
        for (int j = 0; j < 3; j++) begin
          @(negedge clock);
          check({tag, "_rst_no_done"}, bus.done, 1'b0);
        end
        reset = 1'b1;
        @(negedge clock);
        check({tag, "_post_rst_busy"}, bus.busy, 1'b0);
        return;
      end
      if (bus.done) begin
        dones++;
        check({tag, "_latency"}, n, 17);
        check({tag, "_busy_at_done"}, bus.busy, 1'b0);
        if (exp_q.size() != 0) begin
          check({tag, "_formula"}, bus.formula_out, exp_q.pop_front());
          check({tag, "_flags"}, {bus.conflict, bus.satisfied}, exp_flag_q.pop_front());
`ifdef UNIT_DETECT_EN
          check({tag, "_unit"}, {bus.unit_found, bus.unit_lit}, exp_unit_q.pop_front());
`else
          void'(exp_unit_q.pop_front());
`endif
        end
      end else if (n < 17) begin
        check({tag, "_busy"}, bus.busy, 1'b1);
      end
      @(negedge clock);
      n++;
    end
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete();
    exp_flag_q.delete();
    exp_unit_q.delete();
  endtask

  initial begin
    formula f;
    lit     z;
    vectors     = 0;
    miscompares = 0;
    z           = zero_lit;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.formula_in = zero_formula;
    bus.lit_in     = zero_lit;
    repeat (2) @(negedge clock);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_conflict", bus.conflict, 1'b0);
    check("reset_sat", bus.satisfied, 1'b0);
    check("reset_fout", bus.formula_out, zero_formula);
    check("reset_state", dbg_state, IDLE);
`ifdef UNIT_DETECT_EN
    check("reset_unit", {bus.unit_found, bus.unit_lit}, '0);
`endif
    reset = 1'b1;

    // Satisfy: the only live clause is deleted.
    f    = zero_formula;
    f[0] = mk_clause(2, mk_lit(3, 1), mk_lit(5, 0), z, z);
    run_op("satisfy", f, mk_lit(3, 1), -1, -1);
    check("satisfy_c0_len", bus.formula_out[0].len, 0);
    check("satisfy_sat", {bus.conflict, bus.satisfied}, 2'b01);

    // Strike and compact, with junk beyond len in another clause.
    f    = zero_formula;
    f[2] = mk_clause(3, mk_lit(1, 1), mk_lit(4, 0), mk_lit(7, 1), mk_lit(4, 0));
    f[3] = mk_clause(1, mk_lit(6, 1), mk_lit(4, 0), mk_lit(4, 0), mk_lit(9, 1));
    run_op("strike", f, mk_lit(4, 1), -1, -1);
    check("strike_c2", bus.formula_out[2], mk_clause(2, mk_lit(1, 1), mk_lit(7, 1), z, z));
    check("strike_c3", bus.formula_out[3], mk_clause(1, mk_lit(6, 1), z, z, z));

    // Conflict: single-literal clause struck empty.
    f    = zero_formula;
    f[5] = mk_clause(1, mk_lit(9, 0), z, z, z);
    run_op("conflict", f, mk_lit(9, 1), -1, -1);
    check("conflict_flags", {bus.conflict, bus.satisfied}, 2'b10);
    check("conflict_c5_len", bus.formula_out[5].len, 0);
`ifdef UNIT_DETECT_EN
    check("conflict_unit", bus.unit_found, 1'b0);
`endif

    // Unit: clause1 becomes {x2=1}, clause4 is deleted.
    f    = zero_formula;
    f[1] = mk_clause(2, mk_lit(2, 1), mk_lit(6, 1), z, z);
    f[4] = mk_clause(2, mk_lit(6, 0), mk_lit(8, 1), z, z);
    run_op("unit", f, mk_lit(6, 0), -1, -1);
    check("unit_c1", bus.formula_out[1], mk_clause(1, mk_lit(2, 1), z, z, z));
    check("unit_c4_len", bus.formula_out[4].len, 0);
`ifdef UNIT_DETECT_EN
    check("unit_lit", {bus.unit_found, bus.unit_lit}, {1'b1, mk_lit(2, 1)});
`endif

    // Second start mid-scan must be ignored.
    f    = zero_formula;
    f[2] = mk_clause(3, mk_lit(1, 1), mk_lit(4, 0), mk_lit(7, 1), z);
    run_op("handshake", f, mk_lit(4, 1), 5, -1);

    // Reset mid-scan, then a normal request.
    f    = zero_formula;
    f[5] = mk_clause(1, mk_lit(9, 0), z, z, z);
    run_op("midreset", f, mk_lit(9, 1), -1, 8);
    f    = zero_formula;
    f[1] = mk_clause(2, mk_lit(2, 1), mk_lit(6, 1), z, z);
    f[4] = mk_clause(2, mk_lit(6, 0), mk_lit(8, 1), z, z);
    run_op("after_reset", f, mk_lit(6, 0), -1, -1);

    // All slots deleted (junk literals must be left untouched).
    f = rand_formula(7);
    for (int i = 0; i < num_clauses; i++) f[i].len = '0;
    run_op("all_empty", f, mk_lit(1, 1), -1, -1);
    check("all_empty_flags", {bus.conflict, bus.satisfied}, 2'b01);

    // Variable 0, duplicates, and satisfied-wins.
    f    = zero_formula;
    f[0] = mk_clause(3, mk_lit(0, 0), mk_lit(1, 1), mk_lit(0, 0), z);
    f[7] = mk_clause(2, mk_lit(0, 1), mk_lit(0, 0), z, z);
    run_op("var0", f, mk_lit(0, 1), -1, -1);
    check("var0_c0", bus.formula_out[0], mk_clause(1, mk_lit(1, 1), z, z, z));
    check("var0_c7_len", bus.formula_out[7].len, 0);

    for (int r = 0; r < 8; r++) begin
      f = rand_formula((r < 4) ? 5 : 12);
      run_op("random", f, mk_lit($urandom_range(0, 5), $urandom_range(0, 1)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
